// File: rtl/rom_loader_if.sv
// CPU I/O bus as seen by the ROM loader: address, strobes, write data in,
// read data and its output-enable back out.
interface rom_loader_if;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        dout_oe;

  modport master (
    output a, iorq_n, rd_n, wr_n, din,
    input  dout, dout_oe
  );

  modport slave (
    input  a, iorq_n, rd_n, wr_n, din,
    output dout, dout_oe
  );
endinterface

// File: rtl/rom_loader.sv
// ROM loader: three I/O ports set a 13-bit write pointer, push data bytes
// into ROM with a running mod-256 checksum, and report a sticky error when
// a data write arrives while ROM writes are locked.
module rom_loader #(
  parameter int unsigned PORT_ALO  = 124,
  parameter int unsigned PORT_AHI  = 125,
  parameter int unsigned PORT_DATA = 126
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_loader_if.slave  cpu,
  input  logic         enable_write,
  output logic [12:0]  rom_a,
  output logic [7:0]   rom_din,
  output logic         rom_we
);

  localparam logic [7:0] P_ALO  = 8'(PORT_ALO);
  localparam logic [7:0] P_AHI  = 8'(PORT_AHI);
  localparam logic [7:0] P_DATA = 8'(PORT_DATA);

  typedef enum logic [1:0] {IDLE, INIO, COMMIT} state_t;

  state_t      state;
  logic [12:0] ptr;
  logic [7:0]  csum;
  logic        err;
  logic [7:0]  dbuf;
  logic [7:0]  port_id;

  logic [7:0]  addr;
  logic        io_wr;
  logic        hit;
  logic        cycle_end;
  logic        unused_addr_hi;

  // Decode the low address byte and the write strobes
  always_comb begin
    addr           = cpu.a[7:0];
    unused_addr_hi = ^cpu.a[15:8];
    io_wr          = !cpu.iorq_n && !cpu.wr_n;
    hit            = (addr == P_ALO) || (addr == P_AHI) || (addr == P_DATA);
    cycle_end      = !io_wr || (addr != port_id);
  end

  // Write-cycle FSM: latch on start, act on the end edge, one-clock commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      csum    <= '0;
      err     <= 1'b0;
      dbuf    <= '0;
      port_id <= '0;
      rom_a   <= '0;
      rom_din <= '0;
      rom_we  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_wr && hit) begin
            dbuf    <= cpu.din;
            port_id <= addr;
            state   <= INIO;
          end
        end
        INIO: begin
          if (cycle_end) begin
            state <= IDLE;
            if (port_id == P_ALO) begin
              ptr[7:0] <= dbuf;
            end else if (port_id == P_AHI) begin
              ptr[12:8] <= dbuf[4:0];
              csum      <= '0;
              err       <= 1'b0;
            end else if (enable_write) begin
              rom_a   <= ptr;
              rom_din <= dbuf;
              rom_we  <= 1'b1;
              csum    <= csum + dbuf;
              state   <= COMMIT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        COMMIT: begin
          rom_we <= 1'b0;
          ptr    <= ptr + 13'd1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational register readback; bus released (zero) otherwise
  always_comb begin
    cpu.dout    = '0;
    cpu.dout_oe = 1'b0;
    if (!cpu.iorq_n && !cpu.rd_n) begin
      if (addr == P_ALO) begin
        cpu.dout    = ptr[7:0];
        cpu.dout_oe = 1'b1;
      end else if (addr == P_AHI) begin
        cpu.dout    = {err, 2'b00, ptr[12:8]};
        cpu.dout_oe = 1'b1;
      end else if (addr == P_DATA) begin
        cpu.dout    = csum;
        cpu.dout_oe = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed scenarios plus randomized I/O writes,
// checked against a port-level behavioural model of pointer, checksum,
// error flag and the list of ROM writes.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable_write = 1'b0;
  logic [12:0] rom_a;
  logic [7:0]  rom_din;
  logic        rom_we;

  rom_loader_if cpu();

  rom_loader #(
    .PORT_ALO (124),
    .PORT_AHI (125),
    .PORT_DATA(126)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu         (cpu.slave),
    .enable_write(enable_write),
    .rom_a       (rom_a),
    .rom_din     (rom_din),
    .rom_we      (rom_we)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int unsigned m_ptr  = 0;
  int unsigned m_csum = 0;
  bit          m_err  = 1'b0;
  logic [20:0] exp_wr[$];
  logic [20:0] got_wr[$];

  // ROM write observer: one log entry per pulse, longest pulse tracked
  int run = 0;
  int max_run = 0;
  always @(negedge clk) begin
    if (rom_we === 1'b1) begin
      if (run == 0) got_wr.push_back({rom_a, rom_din});
      run = run + 1;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_csum = 0; m_err = 1'b0;
  endtask

  task automatic model_out(input logic [7:0] port, input logic [7:0] data, input logic ew);
    if (port == 8'd124) begin
      m_ptr = (m_ptr & 32'h1F00) | 32'(data);
    end else if (port == 8'd125) begin
      m_ptr  = (m_ptr & 32'hFF) | ((32'(data) % 32) * 256);
      m_csum = 0;
      m_err  = 1'b0;
    end else if (ew) begin
      exp_wr.push_back({13'(m_ptr), data});
      m_csum = (m_csum + 32'(data)) % 256;
      m_ptr  = (m_ptr + 1) % 8192;
    end else begin
      m_err = 1'b1;
    end
  endtask

  // Called at a negedge; returns one negedge after the strobes are released
  task automatic io_out(input logic [7:0] port, input logic [7:0] data, input int hold,
                        input logic ew_mid, input logic ew_end, input logic ew_after);
    cpu.a = {8'($urandom), port};
    cpu.din = data;
    cpu.iorq_n = 1'b0;
    cpu.wr_n = 1'b0;
    enable_write = ew_mid;
    repeat (hold) @(negedge clk);
    cpu.iorq_n = 1'b1;
    cpu.wr_n = 1'b1;
    cpu.din = 8'($urandom);
    enable_write = ew_end;
    model_out(port, data, ew_end);
    @(negedge clk);
    enable_write = ew_after;
  endtask

  task automatic io_in(input logic [7:0] port, output logic [7:0] d, output logic oe);
    cpu.a = {8'($urandom), port};
    cpu.iorq_n = 1'b0;
    cpu.rd_n = 1'b0;
    #1;
    d = cpu.dout;
    oe = cpu.dout_oe;
    cpu.iorq_n = 1'b1;
    cpu.rd_n = 1'b1;
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, ".wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
    n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
    for (int i = 0; i < n; i++) chk({tag, ".wr"}, 32'(got_wr[i]), 32'(exp_wr[i]));
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] d;
    logic oe;
    repeat (2) @(negedge clk);
    io_in(8'd124, d, oe);
    chk({tag, ".ptr_lo"}, 32'(d), m_ptr % 256);
    chk({tag, ".oe124"}, 32'(oe), 32'd1);
    io_in(8'd125, d, oe);
    chk({tag, ".ahi"}, 32'(d), (m_err ? 32'h80 : 32'h0) | (m_ptr / 256));
    io_in(8'd126, d, oe);
    chk({tag, ".csum"}, 32'(d), m_csum);
    check_writes(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic oe;
    logic [7:0] port;
    logic ew;

    cpu.a = '0; cpu.din = '0;
    cpu.iorq_n = 1'b1; cpu.rd_n = 1'b1; cpu.wr_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_wr.delete();
    model_reset();

    // Reset state and idle bus
    chk("rst.rom_we", 32'(rom_we), 32'd0);
    chk("rst.rom_a", 32'(rom_a), 32'd0);
    chk("rst.rom_din", 32'(rom_din), 32'd0);
    chk("idle.dout", 32'(cpu.dout), 32'd0);
    chk("idle.oe", 32'(cpu.dout_oe), 32'd0);
    io_in(8'd127, d, oe);
    chk("undecoded.dout", 32'(d), 32'd0);
    chk("undecoded.oe", 32'(oe), 32'd0);
    check_regs("rst");

    // Basic pointer set and one write
    io_out(8'd125, 8'h00, 2, 1, 1, 1);
    io_out(8'd124, 8'h10, 2, 1, 1, 1);
    io_out(8'd126, 8'hAB, 2, 1, 1, 1);
    check_regs("basic");

    // Pointer wrap 0x1FFF -> 0x0000
    io_out(8'd125, 8'h1F, 3, 1, 1, 1);
    io_out(8'd124, 8'hFF, 2, 1, 1, 1);
    io_out(8'd126, 8'h01, 2, 1, 1, 1);
    io_out(8'd126, 8'h02, 2, 1, 1, 1);
    check_regs("wrap");

    // Locked write sets err, then AHI write clears err and csum
    io_out(8'd126, 8'h55, 2, 0, 0, 0);
    check_regs("locked");
    io_out(8'd125, 8'h00, 2, 1, 1, 1);
    check_regs("clear");

    // Checksum mod-256 wrap
    io_out(8'd126, 8'hFF, 2, 1, 1, 1);
    io_out(8'd126, 8'hFF, 2, 1, 1, 1);
    check_regs("csum_wrap");

    // enable_write dropped mid-cycle rejects; raised late does not matter
    io_out(8'd126, 8'h11, 3, 1, 0, 0);
    check_regs("ew_fall");
    io_out(8'd126, 8'h22, 3, 0, 1, 0);
    @(negedge clk);
    enable_write = 1'b1;
    check_regs("ew_commit");

    // Reset on the edge after the end edge of a data write
    io_out(8'd126, 8'h77, 2, 1, 1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_commit.rom_we", 32'(rom_we), 32'd0);
    chk("rst_commit.rom_a", 32'(rom_a), 32'd0);
    check_regs("rst_commit");

    // Reset during INIO aborts; strobes still active restart from IDLE
    cpu.a = {8'h00, 8'd126};
    cpu.din = 8'h3C;
    cpu.iorq_n = 1'b0;
    cpu.wr_n = 1'b0;
    enable_write = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    cpu.iorq_n = 1'b1;
    cpu.wr_n = 1'b1;
    model_out(8'd126, 8'h3C, 1'b1);
    check_regs("rst_inio");

    // Randomized back-to-back writes, including starts during COMMIT
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: port = 8'd124;
        1: port = 8'd125;
        default: port = 8'd126;
      endcase
      ew = ($urandom_range(0, 3) != 0);
      io_out(port, 8'($urandom), int'($urandom_range(2, 4)), ew, ew, 1'($urandom));
      if (i % 6 == 5) check_regs("rand");
    end
    check_regs("rand_end");

    chk("we_pulse_len", 32'(max_run), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
